// File: rtl/gray_updown_counter.sv
// rtl/gray_updown_counter.sv - registered up/down counter with cycle-aligned binary and Gray outputs
//
// Purpose:
//   One registered binary counter whose Gray image is computed from the next
//   binary value and registered alongside it. This keeps gray_cnt exactly
//   bin_cnt ^ (bin_cnt >> 1) in every cycle. The counter supports parallel
//   load, wrap or saturate at the bounds, a terminal-count pulse, and the
//   index of the single Gray bit that moved on each counting step.
//
// Ports:
//   clk       in   1      rising-edge clock
//   rst       in   1      synchronous reset, active-high (highest priority)
//   enb       in   1      count enable
//   rise      in   1      direction, 1 = up / 0 = down (used only when enb=1)
//   load      in   1      parallel load strobe (overrides enb)
//   load_val  in   WIDTH  binary value to load
//   bin_cnt   out  WIDTH  registered binary count
//   gray_cnt  out  WIDTH  registered Gray code of bin_cnt
//   tc        out  1      terminal-count pulse (bound reached by an enb step)
//   chg_vld   out  1      count moved because of an enb step this cycle
//   chg_idx   out  IDX_W  index of the Gray bit that toggled on the last move

module gray_updown_counter #(
    parameter int                WIDTH   = 12,
    parameter int                WRAP    = 1,
    parameter logic [WIDTH-1:0]  RST_VAL = '0,
    parameter int                IDX_W   = $clog2(WIDTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enb,
    input  logic              rise,
    input  logic              load,
    input  logic [WIDTH-1:0]  load_val,
    output logic [WIDTH-1:0]  bin_cnt,
    output logic [WIDTH-1:0]  gray_cnt,
    output logic              tc,
    output logic              chg_vld,
    output logic [IDX_W-1:0]  chg_idx
);

    localparam logic [WIDTH-1:0] RST_GRAY = RST_VAL ^ (RST_VAL >> 1);

    logic [WIDTH-1:0] bin_next;
    logic [WIDTH-1:0] gray_next;
    logic [WIDTH-1:0] gray_diff;
    logic             tc_next;
    logic             step;
    logic [IDX_W-1:0] idx_next;
    logic             at_max;
    logic             at_min;

    assign at_max = &bin_cnt;
    assign at_min = ~|bin_cnt;

    // Next binary value, terminal-count and "count actually moved" decode.
    // In saturate mode a push against a bound raises tc but not step.
    always_comb begin
        bin_next = bin_cnt;
        tc_next  = 1'b0;
        step     = 1'b0;
        if (load) begin
            bin_next = load_val;
        end else if (enb) begin
            if (rise) begin
                if (!at_max) begin
                    bin_next = bin_cnt + 1'b1;
                    step     = 1'b1;
                end else begin
                    tc_next = 1'b1;
                    if (WRAP != 0) begin
                        bin_next = '0;
                        step     = 1'b1;
                    end
                end
            end else begin
                if (!at_min) begin
                    bin_next = bin_cnt - 1'b1;
                    step     = 1'b1;
                end else begin
                    tc_next = 1'b1;
                    if (WRAP != 0) begin
                        bin_next = '1;
                        step     = 1'b1;
                    end
                end
            end
        end
    end

    // The Gray code comes from the next binary value, so both registers update on the same edge.
    assign gray_next = bin_next ^ (bin_next >> 1);
    assign gray_diff = gray_next ^ gray_cnt;

    // On a one-step move gray_diff is one-hot, so a simple priority scan encodes it.
    always_comb begin
        idx_next = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (gray_diff[i]) begin
                idx_next = IDX_W'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bin_cnt  <= RST_VAL;
            gray_cnt <= RST_GRAY;
            tc       <= 1'b0;
            chg_vld  <= 1'b0;
            chg_idx  <= '0;
        end else begin
            bin_cnt  <= bin_next;
            gray_cnt <= gray_next;
            tc       <= tc_next;
            chg_vld  <= step;
            if (step) begin
                chg_idx <= idx_next;
            end
        end
    end

endmodule

// File: tb/tb_gray_updown_counter.sv
// tb/tb_gray_updown_counter.sv - directed self-checking bench for gray_updown_counter

module tb_gray_updown_counter;

    logic        clk = 1'b0;
    logic        rst;
    logic        enb;
    logic        rise;
    logic        load;
    logic [11:0] load_val;

    logic [3:0]  a_bin, a_gray;
    logic        a_tc, a_vld;
    logic [1:0]  a_idx;
    logic [3:0]  b_bin, b_gray;
    logic        b_tc, b_vld;
    logic [1:0]  b_idx;
    logic [11:0] c_bin, c_gray;
    logic        c_tc, c_vld;
    logic [3:0]  c_idx;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    gray_updown_counter #(.WIDTH(4), .WRAP(1), .RST_VAL(4'h0)) u_wrap (
        .clk(clk), .rst(rst), .enb(enb), .rise(rise), .load(load),
        .load_val(load_val[3:0]), .bin_cnt(a_bin), .gray_cnt(a_gray),
        .tc(a_tc), .chg_vld(a_vld), .chg_idx(a_idx)
    );

    gray_updown_counter #(.WIDTH(4), .WRAP(0), .RST_VAL(4'h0)) u_sat (
        .clk(clk), .rst(rst), .enb(enb), .rise(rise), .load(load),
        .load_val(load_val[3:0]), .bin_cnt(b_bin), .gray_cnt(b_gray),
        .tc(b_tc), .chg_vld(b_vld), .chg_idx(b_idx)
    );

    gray_updown_counter #(.WIDTH(12), .WRAP(1), .RST_VAL(12'h0A5)) u_wide (
        .clk(clk), .rst(rst), .enb(enb), .rise(rise), .load(load),
        .load_val(load_val), .bin_cnt(c_bin), .gray_cnt(c_gray),
        .tc(c_tc), .chg_vld(c_vld), .chg_idx(c_idx)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Inputs are driven between edges; outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic r, input logic e, input logic d,
                         input logic l, input logic [11:0] v);
        rst = r; enb = e; rise = d; load = l; load_val = v;
    endtask

    logic [3:0] gray_seq [0:16] = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                                    4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8, 4'h0};
    logic [3:0] prev_gray;

    initial begin
        drive(1'b1, 1'b1, 1'b1, 1'b0, 12'h000);
        #2;
        tick();
        tick();
        check("rst_bin",  a_bin,  0);
        check("rst_gray", a_gray, 0);
        check("rst_tc",   a_tc,   0);
        check("rst_vld",  a_vld,  0);
        check("rst_idx",  a_idx,  0);
        check("rst_wide_bin",  c_bin,  32'h0A5);
        check("rst_wide_gray", c_gray, 32'h0F7);

        // Up count through a full cycle with wrap.
        drive(1'b0, 1'b1, 1'b1, 1'b0, 12'h000);
        prev_gray = a_gray;
        for (int i = 1; i <= 16; i++) begin
            tick();
            check($sformatf("up_gray_%0d", i), a_gray, gray_seq[i]);
            check($sformatf("up_vld_%0d", i),  a_vld, 1);
            check($sformatf("up_pop_%0d", i),  $countones(prev_gray ^ a_gray), 1);
            check($sformatf("up_tc_%0d", i),   a_tc, (i == 16) ? 1 : 0);
            prev_gray = a_gray;
        end
        check("up_wrap_idx", a_idx, 3);
        check("up_wrap_bin", a_bin, 0);

        // Down wrap from 0.
        drive(1'b0, 1'b1, 1'b0, 1'b0, 12'h000);
        tick();
        check("dn_wrap_bin",  a_bin,  4'hF);
        check("dn_wrap_gray", a_gray, 4'h8);
        check("dn_wrap_tc",   a_tc,   1);
        check("dn_wrap_idx",  a_idx,  3);
        tick();
        check("dn_next_bin",  a_bin,  4'hE);
        check("dn_next_gray", a_gray, 4'h9);
        check("dn_next_tc",   a_tc,   0);
        check("dn_next_idx",  a_idx,  0);

        // Load wins over enable.
        drive(1'b0, 1'b1, 1'b1, 1'b1, 12'h005);
        tick();
        check("ld_bin",  a_bin,  5);
        check("ld_gray", a_gray, 7);
        check("ld_tc",   a_tc,   0);
        check("ld_vld",  a_vld,  0);
        drive(1'b0, 1'b1, 1'b1, 1'b0, 12'h000);
        tick();
        check("ld_up_bin",  a_bin,  6);
        check("ld_up_gray", a_gray, 5);
        check("ld_up_idx",  a_idx,  1);
        check("ld_up_vld",  a_vld,  1);

        // Hold keeps count and index, clears the pulses.
        drive(1'b0, 1'b0, 1'b0, 1'b0, 12'h000);
        tick();
        check("hold_bin", a_bin, 6);
        check("hold_vld", a_vld, 0);
        check("hold_tc",  a_tc,  0);
        check("hold_idx", a_idx, 1);

        // Saturate at the top bound.
        drive(1'b0, 1'b0, 1'b1, 1'b1, 12'h00F);
        tick();
        check("sat_ld_bin", b_bin, 4'hF);
        drive(1'b0, 1'b1, 1'b1, 1'b0, 12'h000);
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("sat_hi_bin_%0d", i),  b_bin,  4'hF);
            check($sformatf("sat_hi_gray_%0d", i), b_gray, 4'h8);
            check($sformatf("sat_hi_tc_%0d", i),   b_tc,   1);
            check($sformatf("sat_hi_vld_%0d", i),  b_vld,  0);
        end

        // Saturate at the bottom bound.
        drive(1'b0, 1'b0, 1'b0, 1'b1, 12'h000);
        tick();
        drive(1'b0, 1'b1, 1'b0, 1'b0, 12'h000);
        tick();
        check("sat_lo_bin", b_bin, 0);
        check("sat_lo_tc",  b_tc,  1);
        check("sat_lo_vld", b_vld, 0);

        // Reset priority on the wide counter.
        drive(1'b0, 1'b0, 1'b1, 1'b1, 12'h7FF);
        tick();
        drive(1'b0, 1'b1, 1'b1, 1'b0, 12'h000);
        tick();
        check("w_up_bin",  c_bin,  32'h800);
        check("w_up_gray", c_gray, 32'hC00);
        check("w_up_idx",  c_idx,  11);
        check("w_up_tc",   c_tc,   0);
        drive(1'b1, 1'b1, 1'b1, 1'b1, 12'h123);
        tick();
        check("w_rst_bin",  c_bin,  32'h0A5);
        check("w_rst_gray", c_gray, 32'h0F7);
        check("w_rst_tc",   c_tc,   0);
        check("w_rst_vld",  c_vld,  0);
        check("w_rst_idx",  c_idx,  0);
        drive(1'b0, 1'b1, 1'b1, 1'b0, 12'h000);
        tick();
        check("w_resume_bin",  c_bin,  32'h0A6);
        check("w_resume_gray", c_gray, 32'h0F5);
        check("w_resume_idx",  c_idx,  1);
        check("w_resume_vld",  c_vld,  1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/gray_updown_counter.md
Name: gray_updown_counter

Overview:
- Parametrised successor to the fixed 12-bit binary counter plus Binary2Gray pair.
- A single registered up/down counter that produces binary and Gray outputs that are cycle-aligned.
- Adds parallel load, wrap or saturate mode, a terminal-count flag and a changed-bit index for downstream Gray consumers, such as pattern generators and CDC pointers.

Parameters:
- WIDTH, 12, counter width in bits (at least 2).
- WRAP, 1, 1 means wrap at the bounds; 0 means saturate at the bounds.
- RST_VAL, 0, binary value loaded on reset (must be less than 2^WIDTH).
- IDX_W, $clog2(WIDTH), width of chg_idx (derived; do not override).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous reset, active-high.
- enb  input  1  count enable.
- rise  input  1  direction: 1 = up, 0 = down. Sampled only when enb=1.
- load  input  1  parallel load strobe.
- load_val  input  WIDTH  binary value to load.
- bin_cnt  output  WIDTH  registered binary count.
- gray_cnt  output  WIDTH  registered Gray code of bin_cnt.
- tc  output  1  terminal-count pulse.
- chg_vld  output  1  1 when the count changed due to an enb step this cycle.
- chg_idx  output  IDX_W  index of the single Gray bit that toggled.

Behaviour:
- All state updates on the rising edge of clk. Every output is a flop; there is no combinational input-to-output path.
- Priority: rst > load > enb > hold.
- Reset values:
  - bin_cnt = RST_VAL.
  - gray_cnt = RST_VAL ^ (RST_VAL >> 1).
  - tc = 0, chg_vld = 0, chg_idx = 0.
- Gray rule: gray_cnt always equals bin_cnt ^ (bin_cnt >> 1) in the same cycle. It is computed from the next binary value and registered, never derived from bin_cnt through a second stage.
- Load:
  - bin_cnt <= load_val; gray_cnt follows.
  - tc <= 0, chg_vld <= 0.
  - enb and rise are ignored that cycle.
- Up step (enb=1, rise=1):
  - Below max (2^WIDTH-1): bin_cnt <= bin_cnt+1; tc <= 0.
  - At max with WRAP=1: bin_cnt <= 0; tc <= 1.
  - At max with WRAP=0: hold; tc <= 1; chg_vld <= 0.
- Down step (enb=1, rise=0):
  - Above 0: bin_cnt <= bin_cnt-1; tc <= 0.
  - At 0 with WRAP=1: bin_cnt <= 2^WIDTH-1; tc <= 1.
  - At 0 with WRAP=0: hold; tc <= 1; chg_vld <= 0.
- Hold (enb=0, load=0): count is unchanged; tc <= 0, chg_vld <= 0; chg_idx holds its last value.
- Changed-bit index:
  - On any step that moves the count (including a wrap), chg_vld <= 1.
  - chg_idx <= index of the one-hot vector gray_next ^ gray_cnt.
  - Wrap in either direction toggles bit WIDTH-1.
- tc is a one-cycle pulse per qualifying step. In saturate mode it re-asserts every cycle that enb pushes against the bound.
- Direction change: takes effect on the same edge rise is sampled; there is no dead cycle.
- Latency: 1 clock from sampled enb/load to updated bin_cnt, gray_cnt, tc, chg_vld and chg_idx.
- Reset mid-operation: all state returns to the reset values on that edge, regardless of enb or load.
- Arithmetic: modulo 2^WIDTH in wrap mode. No carry-out port other than tc.

Test Plan:
- Reset: WIDTH=4, RST_VAL=0; hold rst=1 for 2 cycles with enb=1 -> bin_cnt=0, gray_cnt=0, tc=0, chg_vld=0.
- Up count: WIDTH=4, WRAP=1, enb=1, rise=1 for 17 cycles.
  - gray_cnt sequence: 0,1,3,2,6,7,5,4,C,D,F,E,A,B,9,8,0.
  - Final step: tc=1, chg_idx=3.
  - Every step: chg_vld=1 and popcount(prev ^ gray_cnt)=1.
- Down wrap: WIDTH=4, WRAP=1, from 0 with rise=0 -> bin_cnt=F, gray_cnt=8, tc=1, chg_idx=3. Next step -> bin_cnt=E, gray_cnt=9, chg_idx=0.
- Saturate: WIDTH=4, WRAP=0; load F, then 3 cycles with enb=1, rise=1 -> bin_cnt stays F, gray_cnt stays 8, tc=1 each cycle, chg_vld=0.
- Load vs enable: load=1, load_val=5, enb=1 in the same cycle -> bin_cnt=5, gray_cnt=7, tc=0, chg_vld=0. Next enb cycle with rise=1 -> bin_cnt=6, gray_cnt=5, chg_idx=1.
- Reset priority: WIDTH=12, counting at 0x7FF; assert rst with load=1 and enb=1 -> next edge bin_cnt=RST_VAL, all flags 0. Counting resumes from RST_VAL one cycle after rst drops.
